// File: rtl/seg_readback_decoder.sv
// Segment readback monitor: waits for the two-digit segment pattern to hold
// steady, then decodes it back to 0-59 and flags illegal or dark patterns.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_SETTLE  | a new pattern was captured; counting identical samples
// ST_LOCKED  | current pattern has been evaluated; waiting for a change
module seg_readback_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int ERR_CNT_W     = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [6:0]           SEGL,
  input  logic [6:0]           SEGR,
  output logic [5:0]           NUM,
  output logic                 VALID,
  output logic                 ERR,
  output logic                 BLANK,
  output logic [ERR_CNT_W-1:0] ERR_CNT
);

  typedef enum logic {ST_SETTLE, ST_LOCKED} state_t;

  // Count runs 0..STABLE_CYCLES-1; evaluation fires on the edge after the last value.
  localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = {ERR_CNT_W{1'b1}};

  state_t                 state_q, state_d;
  logic [13:0]            h_q, h_d;
  logic [7:0]             cnt_q, cnt_d;
  logic [5:0]             num_q, num_d;
  logic                   valid_q, valid_d;
  logic                   err_q, err_d;
  logic                   blank_q, blank_d;
  logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;

  logic [13:0]            sample;
  logic [4:0]             dec_l, dec_r;
  logic                   pair_legal;
  logic                   pair_dark;
  logic [5:0]             pair_value;

  // Returns {legal, digit}; digit is meaningless when legal is 0.
  function automatic logic [4:0] seg_decode(input logic [6:0] seg);
    case (seg)
      7'h3F:   seg_decode = {1'b1, 4'd0};
      7'h06:   seg_decode = {1'b1, 4'd1};
      7'h5B:   seg_decode = {1'b1, 4'd2};
      7'h4F:   seg_decode = {1'b1, 4'd3};
      7'h66:   seg_decode = {1'b1, 4'd4};
      7'h6D:   seg_decode = {1'b1, 4'd5};
      7'h7D:   seg_decode = {1'b1, 4'd6};
      7'h07:   seg_decode = {1'b1, 4'd7};
      7'h7F:   seg_decode = {1'b1, 4'd8};
      7'h6F:   seg_decode = {1'b1, 4'd9};
      default: seg_decode = {1'b0, 4'd0};
    endcase
  endfunction

  assign sample     = {SEGL, SEGR};
  assign dec_l      = seg_decode(h_q[13:7]);
  assign dec_r      = seg_decode(h_q[6:0]);
  // Tens digit of a minutes/seconds field only goes up to 5.
  assign pair_legal = dec_l[4] && (dec_l[3:0] <= 4'd5) && dec_r[4];
  assign pair_dark  = (h_q == 14'd0);
  assign pair_value = ({2'b00, dec_l[3:0]} * 6'd10) + {2'b00, dec_r[3:0]};

  // Next-state logic: track the held sample, count stability, evaluate on lock.
  always_comb begin
    state_d   = state_q;
    h_d       = h_q;
    cnt_d     = cnt_q;
    num_d     = num_q;
    valid_d   = 1'b0;
    err_d     = err_q;
    blank_d   = blank_q;
    err_cnt_d = err_cnt_q;
    if (sample != h_q) begin
      h_d     = sample;
      cnt_d   = 8'd0;
      state_d = ST_SETTLE;
    end else if (state_q == ST_SETTLE) begin
      if (cnt_q < CNT_LAST) begin
        cnt_d = cnt_q + 8'd1;
      end else begin
        state_d = ST_LOCKED;
        if (pair_legal) begin
          num_d   = pair_value;
          valid_d = 1'b1;
          err_d   = 1'b0;
          blank_d = 1'b0;
        end else if (pair_dark) begin
          blank_d = 1'b1;
          err_d   = 1'b0;
        end else begin
          err_d   = 1'b1;
          blank_d = 1'b0;
          if (err_cnt_q != ERR_CNT_MAX) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
      end
    end
  end

  // State and output registers; reset wins over any evaluation on the same edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_SETTLE;
      h_q       <= 14'd0;
      cnt_q     <= 8'd0;
      num_q     <= 6'd0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      blank_q   <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      h_q       <= h_d;
      cnt_q     <= cnt_d;
      num_q     <= num_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      blank_q   <= blank_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign NUM     = num_q;
  assign VALID   = valid_q;
  assign ERR     = err_q;
  assign BLANK   = blank_q;
  assign ERR_CNT = err_cnt_q;

endmodule

// File: tb/tb_seg_readback_decoder.sv
// Bench for seg_readback_decoder: run-length reference model checked every
// cycle, plus literal checks at the points of interest.
module tb_seg_readback_decoder;

  localparam int S = 4;

  logic       clk;
  logic       rst;
  logic [6:0] segl, segr;

  logic [5:0] num,  num2;
  logic       valid, valid2, err, err2, blank, blank2;
  logic [7:0] err_cnt;
  logic [1:0] err_cnt2;

  seg_readback_decoder #(.STABLE_CYCLES(S), .ERR_CNT_W(8)) dut (
    .CLK(clk), .RST(rst), .SEGL(segl), .SEGR(segr),
    .NUM(num), .VALID(valid), .ERR(err), .BLANK(blank), .ERR_CNT(err_cnt)
  );

  seg_readback_decoder #(.STABLE_CYCLES(S), .ERR_CNT_W(2)) dut2 (
    .CLK(clk), .RST(rst), .SEGL(segl), .SEGR(segr),
    .NUM(num2), .VALID(valid2), .ERR(err2), .BLANK(blank2), .ERR_CNT(err_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int vcount = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Digit index of a segment code, -1 when not a legal digit.
  function automatic int digit_of(input logic [6:0] c);
    case (c)
      7'h3F: return 0;  7'h06: return 1;  7'h5B: return 2;  7'h4F: return 3;
      7'h66: return 4;  7'h6D: return 5;  7'h7D: return 6;  7'h07: return 7;
      7'h7F: return 8;  7'h6F: return 9;
      default: return -1;
    endcase
  endfunction

  // Reference model: a pattern is evaluated once, on the edge where it has
  // been seen on S+1 consecutive edges (reset edges count as seeing 0).
  int          run;
  logic [13:0] last;
  logic        ready = 1'b0;
  int          m_num, m_cnt, m_cnt2;
  logic        m_valid, m_err, m_blank;

  always @(posedge clk) begin
    if (rst) begin
      run <= 1; last <= 14'd0; ready <= 1'b1;
      m_num <= 0; m_valid <= 1'b0; m_err <= 1'b0; m_blank <= 1'b0;
      m_cnt <= 0; m_cnt2 <= 0;
    end else begin
      m_valid <= 1'b0;
      if ({segl, segr} != last) begin
        last <= {segl, segr};
        run  <= 1;
      end else if (run < S) begin
        run <= run + 1;
      end else if (run == S) begin
        run <= S + 1;
        if (digit_of(last[13:7]) >= 0 && digit_of(last[13:7]) <= 5 && digit_of(last[6:0]) >= 0) begin
          m_num   <= digit_of(last[13:7]) * 10 + digit_of(last[6:0]);
          m_valid <= 1'b1; m_err <= 1'b0; m_blank <= 1'b0;
        end else if (last == 14'd0) begin
          m_blank <= 1'b1; m_err <= 1'b0;
        end else begin
          m_err <= 1'b1; m_blank <= 1'b0;
          if (m_cnt < 255) m_cnt <= m_cnt + 1;
          if (m_cnt2 < 3) m_cnt2 <= m_cnt2 + 1;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the rising edge.
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    if (ready) begin
      chk("num", int'(num), m_num);
      chk("valid", int'(valid), int'(m_valid));
      chk("err", int'(err), int'(m_err));
      chk("blank", int'(blank), int'(m_blank));
      chk("err_cnt", int'(err_cnt), m_cnt);
      chk("num2", int'(num2), m_num);
      chk("valid2", int'(valid2), int'(m_valid));
      chk("err2", int'(err2), int'(m_err));
      chk("blank2", int'(blank2), int'(m_blank));
      chk("err_cnt2", int'(err_cnt2), m_cnt2);
      if (prev_valid) chk("valid_back_to_back", int'(valid), 0);
      prev_valid = valid;
      if (valid) vcount++;
    end
  end

  task automatic set_seg(input logic [6:0] l, input logic [6:0] r);
    @(negedge clk);
    segl = l;
    segr = r;
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  int v0;

  initial begin
    rst = 1'b1; segl = 7'h00; segr = 7'h00;
    hold(3);
    chk("reset_num", int'(num), 0);
    chk("reset_err_cnt", int'(err_cnt), 0);

    // Dark display after release: BLANK on the 4th edge
    rst = 1'b0;
    hold(3);
    chk("dark_blank_early", int'(blank), 0);
    hold(1);
    chk("dark_blank", int'(blank), 1);
    chk("dark_valid", vcount, 0);

    // "23": VALID exactly 4 edges after capture
    rst = 1'b1; hold(2);
    @(negedge clk); rst = 1'b0; segl = 7'h5B; segr = 7'h4F;
    hold(4);
    chk("t1_valid_early", int'(valid), 0);
    hold(1);
    chk("t1_valid", int'(valid), 1);
    chk("t1_num", int'(num), 23);
    chk("t1_err", int'(err), 0);
    hold(1);
    chk("t1_valid_drop", int'(valid), 0);

    // "59" steady, then "00"
    v0 = vcount;
    set_seg(7'h6D, 7'h6F); hold(20);
    chk("t2_pulses_59", vcount - v0, 1);
    chk("t2_num_59", int'(num), 59);
    v0 = vcount;
    set_seg(7'h3F, 7'h3F); hold(20);
    chk("t2_pulses_00", vcount - v0, 1);
    chk("t2_num_00", int'(num), 0);

    // "41" with a 2-sample glitch to "48"
    set_seg(7'h66, 7'h06); hold(10);
    v0 = vcount;
    set_seg(7'h66, 7'h7F); hold(1);
    set_seg(7'h66, 7'h06);
    hold(3);
    chk("t3_no_valid_glitch", vcount - v0, 0);
    hold(7);
    chk("t3_pulses", vcount - v0, 1);
    chk("t3_num", int'(num), 41);
    chk("t3_err", int'(err), 0);

    // Illegal tens digit, then "12"
    set_seg(7'h7D, 7'h3F); hold(10);
    chk("t4_err", int'(err), 1);
    chk("t4_err_cnt", int'(err_cnt), 1);
    chk("t4_num_held", int'(num), 41);
    v0 = vcount;
    set_seg(7'h06, 7'h5B); hold(10);
    chk("t4_err_clear", int'(err), 0);
    chk("t4_pulses", vcount - v0, 1);
    chk("t4_num", int'(num), 12);

    // Both dark, then five illegal patterns
    v0 = vcount;
    set_seg(7'h00, 7'h00); hold(10);
    chk("t5_blank", int'(blank), 1);
    chk("t5_err", int'(err), 0);
    chk("t5_no_valid", vcount - v0, 0);
    set_seg(7'h7D, 7'h3F); hold(8);
    set_seg(7'h06, 7'h00); hold(8);
    set_seg(7'h00, 7'h06); hold(8);
    set_seg(7'h7F, 7'h7F); hold(8);
    set_seg(7'h3F, 7'h01); hold(8);
    chk("t5_err_cnt_w8", int'(err_cnt), 6);
    chk("t5_err_cnt_w2_sat", int'(err_cnt2), 3);
    chk("t5_blank_clear", int'(blank), 0);

    // Reset on the edge that would evaluate "30"
    set_seg(7'h4F, 7'h3F);
    hold(4);
    rst = 1'b1;
    hold(1);
    chk("t6_valid_rst", int'(valid), 0);
    chk("t6_num_rst", int'(num), 0);
    rst = 1'b0;
    hold(4);
    chk("t6_valid_early", int'(valid), 0);
    hold(1);
    chk("t6_valid", int'(valid), 1);
    chk("t6_num", int'(num), 30);
    hold(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
